// File: rtl/camera_pkg.sv
// Shared types, geometry defaults and width helpers for the camera capture path.
package camera_pkg;

   typedef enum logic [1:0] {
      WAIT_SYNC,
      IN_SYNC,
      FRAME
   } cam_state_e;

   // Sensor geometry; the fake camera uses the same numbers.
   localparam int DEF_WIDTH  = 1280;
   localparam int DEF_HEIGHT = 800;
   localparam int H_PORCH    = 4;   // href-low cycles between lines
   localparam int V_PORCH    = 6;   // idle cycles between vsync rise and first line

   // Counter width for values 0..n-1, never below one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/camera_if.sv
// Tagged pixel stream leaving the capture block.
interface camera_if
   import camera_pkg::*;
#(
   parameter int PCLK_PER_PIXEL = 1,
   parameter int WIDTH          = DEF_WIDTH,
   parameter int HEIGHT         = DEF_HEIGHT
);
   localparam int PW = 8 * PCLK_PER_PIXEL;
   localparam int XW = cnt_w(WIDTH);
   localparam int YW = cnt_w(HEIGHT);

   logic          pixelValid;
   logic [PW-1:0] pixelData;
   logic [XW-1:0] pixelX;
   logic [YW-1:0] pixelY;
   logic          startOfFrame;
   logic          endOfLine;

   modport master (output pixelValid, pixelData, pixelX, pixelY, startOfFrame, endOfLine);
   modport slave  (input  pixelValid, pixelData, pixelX, pixelY, startOfFrame, endOfLine);

endinterface

// File: rtl/camera_byte_packer.sv
// Collects PCLK_PER_PIXEL bytes (MSB byte first) into one registered pixel.
module camera_byte_packer
   import camera_pkg::*;
#(
   parameter int PCLK_PER_PIXEL = 1
) (
   input  logic                        pclk,
   input  logic                        reset,
   input  logic                        clear_i,
   input  logic                        byteVld_i,
   input  logic [7:0]                  byte_i,
   output logic                        last_o,
   output logic                        pixVld_o,
   output logic [8*PCLK_PER_PIXEL-1:0] pixData_o
);
   localparam int PW = 8 * PCLK_PER_PIXEL;
   localparam int BW = cnt_w(PCLK_PER_PIXEL);

   logic [BW-1:0] byteCnt_q, byteCnt_d;
   logic [PW-1:0] shift_q, shift_d;
   logic          pixVld_q;
   logic [PW-1:0] pixData_q;

   // Truncating the concatenation keeps the newest PW bits: older bytes move up.
   assign shift_d   = PW'({shift_q, byte_i});
   assign last_o    = byteVld_i && (byteCnt_q == BW'(PCLK_PER_PIXEL - 1));
   assign byteCnt_d = last_o ? '0 : byteCnt_q + BW'(1);

   // Shift bytes in and register the completed pixel (this is the output stage).
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         byteCnt_q <= '0;
         shift_q   <= '0;
         pixVld_q  <= 1'b0;
         pixData_q <= '0;
      end else begin
         pixVld_q <= last_o;
         if (clear_i) begin
            byteCnt_q <= '0;
         end else if (byteVld_i) begin
            byteCnt_q <= byteCnt_d;
            shift_q   <= shift_d;
         end
         if (last_o) pixData_q <= shift_d;
      end
   end

   assign pixVld_o  = pixVld_q;
   assign pixData_o = pixData_q;

endmodule

// File: rtl/camera_capture.sv
// Parallel camera receiver: frame lock on vsync, pixel packing, x/y tagging and
// per-frame geometry check.
module camera_capture
   import camera_pkg::*;
#(
   parameter int PCLK_PER_PIXEL = 1,
   parameter int WIDTH          = DEF_WIDTH,
   parameter int HEIGHT         = DEF_HEIGHT
) (
   input  logic            pclk,
   input  logic            reset,
   input  logic            enable,
   input  logic            href,
   input  logic            vsync,
   input  logic [7:0]      camData,
   camera_if.master        pix,
   output logic            frameDone,
   output logic            frameOk,
   output logic            capturing
);
   localparam int PW = 8 * PCLK_PER_PIXEL;
   localparam int XW = cnt_w(WIDTH);
   localparam int YW = cnt_w(HEIGHT);
   localparam int LW = cnt_w(HEIGHT + 1);   // line count must reach HEIGHT
   localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);

   logic       href_q, vsync_q, hrefPrev_q, vsyncPrev_q;
   logic [7:0] camData_q;
   logic       hrefFall, vsyncFall;

   cam_state_e    state_q, state_d;
   logic          captureEn_q, captureEn_d;
   logic [XW-1:0] x_q, x_d;
   logic [LW-1:0] line_q, line_d;
   logic          lineFull_q, lineFull_d;
   logic          lineErr_q, lineErr_d;
   logic          heightErr_q, heightErr_d;
   logic          frameDone_q, frameDone_d;
   logic          frameOk_q, frameOk_d;
   logic          frameFull, accept, packClear, pixLast, pixVld;
   logic [PW-1:0] pixData;

   logic [XW-1:0] pixelX_q;
   logic [YW-1:0] pixelY_q;
   logic          sof_q, eol_q;

   // Pad stage: downstream logic only sees registered pins and their history.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         href_q      <= 1'b0;
         vsync_q     <= 1'b1;
         camData_q   <= '0;
         hrefPrev_q  <= 1'b0;
         vsyncPrev_q <= 1'b1;
      end else begin
         href_q      <= href;
         vsync_q     <= vsync;
         camData_q   <= camData;
         hrefPrev_q  <= href_q;
         vsyncPrev_q <= vsync_q;
      end
   end

   assign hrefFall  = hrefPrev_q && !href_q;
   assign vsyncFall = vsyncPrev_q && !vsync_q;
   assign frameFull = (line_q == LW'(HEIGHT));
   // Bytes past a full line or past the last line never reach the packer.
   assign accept    = (state_q == FRAME) && captureEn_q && href_q && !lineFull_q && !frameFull;

   camera_byte_packer #(.PCLK_PER_PIXEL(PCLK_PER_PIXEL)) u_packer (
      .pclk      (pclk),
      .reset     (reset),
      .clear_i   (packClear),
      .byteVld_i (accept),
      .byte_i    (camData_q),
      .last_o    (pixLast),
      .pixVld_o  (pixVld),
      .pixData_o (pixData)
   );

   // Frame FSM next state, x/y counters and geometry error tracking.
   always_comb begin
      state_d     = state_q;
      captureEn_d = captureEn_q;
      x_d         = x_q;
      line_d      = line_q;
      lineFull_d  = lineFull_q;
      lineErr_d   = lineErr_q;
      heightErr_d = heightErr_q;
      frameDone_d = 1'b0;
      frameOk_d   = frameOk_q;
      packClear   = (state_q != FRAME);
      case (state_q)
         WAIT_SYNC: if (!vsync_q) state_d = IN_SYNC;
         IN_SYNC: begin
            if (vsync_q) begin
               state_d     = FRAME;
               captureEn_d = enable;
               x_d         = '0;
               line_d      = '0;
               lineFull_d  = 1'b0;
               lineErr_d   = 1'b0;
               heightErr_d = 1'b0;
            end
         end
         FRAME: begin
            if (captureEn_q) begin
               if (href_q && frameFull) heightErr_d = 1'b1;
               else if (href_q && lineFull_q) lineErr_d = 1'b1;
               if (pixLast) begin
                  if (x_q == XMAX) begin
                     x_d        = '0;
                     lineFull_d = 1'b1;
                  end else begin
                     x_d = x_q + XW'(1);
                  end
               end
               if (hrefFall) begin
                  packClear  = 1'b1;
                  x_d        = '0;
                  lineFull_d = 1'b0;
                  if (!frameFull) begin
                     line_d = line_q + LW'(1);
                     if (!lineFull_q) lineErr_d = 1'b1;
                  end
               end
            end
            if (vsyncFall) begin
               state_d = IN_SYNC;
               if (captureEn_q) begin
                  frameDone_d = 1'b1;
                  // href still high here means the last line was cut short.
                  frameOk_d   = !lineErr_d && !heightErr_d && !href_q &&
                                (line_d == LW'(HEIGHT));
               end
            end
         end
         default: state_d = WAIT_SYNC;
      endcase
   end

   // Frame state and status registers.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state_q     <= WAIT_SYNC;
         captureEn_q <= 1'b0;
         x_q         <= '0;
         line_q      <= '0;
         lineFull_q  <= 1'b0;
         lineErr_q   <= 1'b0;
         heightErr_q <= 1'b0;
         frameDone_q <= 1'b0;
         frameOk_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         captureEn_q <= captureEn_d;
         x_q         <= x_d;
         line_q      <= line_d;
         lineFull_q  <= lineFull_d;
         lineErr_q   <= lineErr_d;
         heightErr_q <= heightErr_d;
         frameDone_q <= frameDone_d;
         frameOk_q   <= frameOk_d;
      end
   end

   // Coordinates and markers registered alongside the packed pixel.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         pixelX_q <= '0;
         pixelY_q <= '0;
         sof_q    <= 1'b0;
         eol_q    <= 1'b0;
      end else if (pixLast) begin
         pixelX_q <= x_q;
         pixelY_q <= YW'(line_q);
         sof_q    <= (x_q == '0) && (line_q == '0);
         eol_q    <= (x_q == XMAX);
      end else begin
         sof_q <= 1'b0;
         eol_q <= 1'b0;
      end
   end

   assign pix.pixelValid   = pixVld;
   assign pix.pixelData    = pixData;
   assign pix.pixelX       = pixelX_q;
   assign pix.pixelY       = pixelY_q;
   assign pix.startOfFrame = sof_q;
   assign pix.endOfLine    = eol_q;
   assign frameDone        = frameDone_q;
   assign frameOk          = frameOk_q;
   assign capturing        = (state_q == FRAME) && captureEn_q;

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture with a fake camera and pixel/frame scoreboards.
module tb_camera_capture;
   import camera_pkg::*;

   localparam int PPP = 2;
   localparam int W   = 8;
   localparam int H   = 4;

   typedef struct {
      logic [15:0] data;
      int          x;
      int          y;
      bit          sof;
      bit          eol;
   } pix_t;

   logic       pclk, reset, enable, href, vsync;
   logic [7:0] camData;
   logic       frameDone, frameOk, capturing;

   camera_if #(.PCLK_PER_PIXEL(PPP), .WIDTH(W), .HEIGHT(H)) pix_if ();

   camera_capture #(.PCLK_PER_PIXEL(PPP), .WIDTH(W), .HEIGHT(H)) dut (
      .pclk      (pclk),
      .reset     (reset),
      .enable    (enable),
      .href      (href),
      .vsync     (vsync),
      .camData   (camData),
      .pix       (pix_if.master),
      .frameDone (frameDone),
      .frameOk   (frameOk),
      .capturing (capturing)
   );

   int   errs = 0, checks = 0;
   int   cyc = 0, pixCnt = 0, doneCnt = 0, sofCyc = 0, cdCyc = 0;
   pix_t pixQ[$];
   bit   doneQ[$];
   pix_t e;

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   initial forever begin
      @(posedge pclk);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pixel and frame-status scoreboard, sampled mid-cycle.
   initial forever begin
      @(negedge pclk);
      if (!reset) begin
         if (pix_if.pixelValid) begin
            pixCnt++;
            if (pix_if.startOfFrame) sofCyc = cyc;
            chk("pixel_expected", pixQ.size() != 0, 1);
            if (pixQ.size() != 0) begin
               e = pixQ.pop_front();
               chk("pixelData", pix_if.pixelData, e.data);
               chk("pixelX", pix_if.pixelX, e.x);
               chk("pixelY", pix_if.pixelY, e.y);
               chk("startOfFrame", pix_if.startOfFrame, e.sof);
               chk("endOfLine", pix_if.endOfLine, e.eol);
            end
         end
         if (frameDone) begin
            doneCnt++;
            chk("frameDone_expected", doneQ.size() != 0, 1);
            if (doneQ.size() != 0) chk("frameOk", frameOk, doneQ.pop_front());
         end
      end
   end

   task automatic step(input logic h, input logic v, input logic [7:0] d);
      @(posedge pclk);
      #1;
      href = h; vsync = v; camData = d;
   endtask

   // Fake camera: sync pulse, porch, nlines lines, then vsync falls.
   task automatic run_frame(input int nlines, input int longLine, input bit en,
                            input bit raiseMid, input bit abcd);
      int         nb;
      logic [7:0] b, hi;
      bit         ok;
      hi = 8'h00;
      enable = en;
      ok = (nlines == H) && (longLine < 0);
      repeat (3) step(1'b0, 1'b0, 8'h00);
      repeat (V_PORCH) step(1'b0, 1'b1, 8'h00);
      for (int l = 0; l < nlines; l++) begin
         if (raiseMid && l == 1) enable = 1'b1;
         nb = (l == longLine) ? W*PPP + 2 : W*PPP;
         for (int i = 0; i < nb; i++) begin
            b = 8'($urandom_range(0, 255));
            if (abcd && l == 0 && i == 0) b = 8'hAB;
            if (abcd && l == 0 && i == 1) b = 8'hCD;
            step(1'b1, 1'b1, b);
            if (i % 2 == 0) hi = b;
            else if (en && l < H && i/2 < W) begin
               pixQ.push_back('{data: {hi, b}, x: i/2, y: l,
                                sof: (i == 1 && l == 0), eol: (i/2 == W-1)});
               if (abcd && l == 0 && i == 1) cdCyc = cyc;
            end
         end
         repeat (H_PORCH) step(1'b0, 1'b1, 8'h00);
      end
      if (en) doneQ.push_back(ok);
      repeat (5) step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic frame_checks(input string tag, input int expPix, input int expDone);
      chk({tag, "_pixels"}, pixCnt, expPix);
      chk({tag, "_frameDone"}, doneCnt, expDone);
      chk({tag, "_pixQ_drained"}, pixQ.size(), 0);
      chk({tag, "_doneQ_drained"}, doneQ.size(), 0);
      pixCnt = 0;
      doneCnt = 0;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; href = 1'b0; vsync = 1'b1; camData = 8'h00;
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      chk("rst_pixelValid", pix_if.pixelValid, 0);
      chk("rst_pixelData", pix_if.pixelData, 0);
      chk("rst_pixelX", pix_if.pixelX, 0);
      chk("rst_pixelY", pix_if.pixelY, 0);
      chk("rst_sof", pix_if.startOfFrame, 0);
      chk("rst_eol", pix_if.endOfLine, 0);
      chk("rst_frameDone", frameDone, 0);
      chk("rst_frameOk", frameOk, 0);
      chk("rst_capturing", capturing, 0);
      @(posedge pclk); #1 reset = 1'b0;

      run_frame(H, -1, 1'b1, 1'b0, 1'b1);
      chk("latency_AB_CD", sofCyc - cdCyc, 2);
      frame_checks("clean", W*H, 1);

      run_frame(H, 1, 1'b1, 1'b0, 1'b0);
      frame_checks("long_line", W*H, 1);
      run_frame(H, -1, 1'b1, 1'b0, 1'b0);
      frame_checks("recover", W*H, 1);

      run_frame(3, -1, 1'b1, 1'b0, 1'b0);
      frame_checks("short_frame", W*3, 1);
      run_frame(5, -1, 1'b1, 1'b0, 1'b0);
      frame_checks("tall_frame", W*H, 1);

      run_frame(H, -1, 1'b0, 1'b1, 1'b0);
      frame_checks("disabled", 0, 0);
      run_frame(H, -1, 1'b1, 1'b0, 1'b0);
      frame_checks("reenabled", W*H, 1);

      // Reset in the middle of a line.
      repeat (3) step(1'b0, 1'b0, 8'h00);
      repeat (3) step(1'b0, 1'b1, 8'h00);
      chk("capturing_in_frame", capturing, 1);
      step(1'b1, 1'b1, 8'h11);
      step(1'b1, 1'b1, 8'h22);
      pixQ.push_back('{data: 16'h1122, x: 0, y: 0, sof: 1'b1, eol: 1'b0});
      step(1'b1, 1'b1, 8'h33);
      @(posedge pclk);
      @(posedge pclk);
      #1 reset = 1'b1;
      @(negedge pclk);
      chk("midrst_pixelValid", pix_if.pixelValid, 0);
      chk("midrst_pixelData", pix_if.pixelData, 0);
      chk("midrst_pixelX", pix_if.pixelX, 0);
      chk("midrst_pixelY", pix_if.pixelY, 0);
      chk("midrst_sof", pix_if.startOfFrame, 0);
      chk("midrst_eol", pix_if.endOfLine, 0);
      chk("midrst_frameDone", frameDone, 0);
      chk("midrst_frameOk", frameOk, 0);
      chk("midrst_capturing", capturing, 0);
      frame_checks("before_reset", 1, 0);
      repeat (2) @(posedge pclk);
      #1 reset = 1'b0;
      // Lines without a preceding vsync pulse must be ignored.
      for (int l = 0; l < 2; l++) begin
         for (int i = 0; i < W*PPP; i++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
         repeat (H_PORCH) step(1'b0, 1'b1, 8'h00);
      end
      chk("post_reset_capturing", capturing, 0);
      frame_checks("post_reset_nosync", 0, 0);
      run_frame(H, -1, 1'b1, 1'b0, 1'b0);
      frame_checks("post_reset_frame", W*H, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
